dvi_tx_timing_ctrl: RTL



---
 rtl/dvi_tx_timing_pkg.sv | 32 +++
 rtl/dvi_tx_timing_ctrl_counter.sv | 70 +++++++
 rtl/dvi_tx_timing_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dvi_tx_timing_pkg.sv
// Shared types and default raster constants for the DVI TX video timing controller.
package dvi_tx_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE = 160;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 16;
  localparam int DEF_H_BP     = 16;
  localparam int DEF_V_ACTIVE = 120;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 4;

  // Same formula serves both axes: active + front porch + sync + back porch.
  function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return raster_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return raster_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/dvi_tx_timing_ctrl_counter.sv
// Horizontal/vertical raster counters with region decode (polarity-free, unregistered).
module video_timing_counter
  import dvi_tx_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic first_o,
  output logic last_o
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last_s, v_last_s;

  assign h_last_s = (h_cnt_q == HW'(H_TOTAL - 1));
  assign v_last_s = (v_cnt_q == VW'(V_TOTAL - 1));

  // Counters only move while the controller is busy; otherwise they park at the frame origin.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_i) begin
      if (h_last_s) begin
        h_cnt_d = '0;
        v_cnt_d = v_last_s ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end else begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  assign hsync_o  = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  // v_cnt only changes on the h wrap, so vsync edges land on h_cnt==0.
  assign vsync_o  = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign first_o  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign last_o   = h_last_s && v_last_s;

endmodule

// File: rtl/dvi_tx_timing_ctrl.sv
// DVI TX video timing controller: run/drain FSM, pixel handshake and registered output stage.
module dvi_tx_timing_ctrl
  import dvi_tx_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst,
  input  logic       I_en,
  input  logic       I_pix_valid,
  input  logic [7:0] I_pix_r,
  input  logic [7:0] I_pix_g,
  input  logic [7:0] I_pix_b,
  input  logic       I_underflow_clr,
  output logic       O_pix_req,
  output logic       O_rgb_vs,
  output logic       O_rgb_hs,
  output logic       O_rgb_de,
  output logic [7:0] O_rgb_r,
  output logic [7:0] O_rgb_g,
  output logic [7:0] O_rgb_b,
  output logic       O_frame_start,
  output logic       O_underflow,
  output logic       O_busy
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  logic [1:0] state_q, state_d;
  logic       busy_s, pix_req_s, pix_ok_s, underflow_s;
  logic       active_s, hsync_s, vsync_s, first_s, last_s;

  logic       de_q, hs_q, vs_q, fs_q, uf_q;
  logic [7:0] r_q, g_q, b_q;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clk_i    (I_rgb_clk),
    .rst_i    (I_rst),
    .run_i    (busy_s),
    .active_o (active_s),
    .hsync_o  (hsync_s),
    .vsync_o  (vsync_s),
    .first_o  (first_s),
    .last_o   (last_s)
  );

  // Stopping is deferred to the last pixel of the frame so the link never sees a partial frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (I_en) state_d = RUN;
        else      state_d = IDLE;
      end
      RUN: begin
        if (!I_en) state_d = DRAIN;
        else       state_d = RUN;
      end
      DRAIN: begin
        if (I_en)        state_d = RUN;
        else if (last_s) state_d = IDLE;
        else             state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy_s      = (state_q != IDLE);
  assign pix_req_s   = busy_s && active_s;
  assign pix_ok_s    = pix_req_s && I_pix_valid;
  assign underflow_s = pix_req_s && !I_pix_valid;

  // Single output stage keeps sync, DE, data and frame marker phase-aligned.
  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      fs_q <= 1'b0;
      uf_q <= 1'b0;
      r_q  <= 8'd0;
      g_q  <= 8'd0;
      b_q  <= 8'd0;
    end else begin
      de_q <= pix_req_s;
      hs_q <= (busy_s && hsync_s) ? HS_POL : ~HS_POL;
      vs_q <= (busy_s && vsync_s) ? VS_POL : ~VS_POL;
      fs_q <= pix_req_s && first_s;
      r_q  <= pix_ok_s ? I_pix_r : 8'd0;
      g_q  <= pix_ok_s ? I_pix_g : 8'd0;
      b_q  <= pix_ok_s ? I_pix_b : 8'd0;
      // A fresh underflow beats a simultaneous clear.
      if (underflow_s)          uf_q <= 1'b1;
      else if (I_underflow_clr) uf_q <= 1'b0;
      else                      uf_q <= uf_q;
    end
  end

  assign O_pix_req     = pix_req_s;
  assign O_busy        = busy_s;
  assign O_rgb_de      = de_q;
  assign O_rgb_hs      = hs_q;
  assign O_rgb_vs      = vs_q;
  assign O_rgb_r       = r_q;
  assign O_rgb_g       = g_q;
  assign O_rgb_b       = b_q;
  assign O_frame_start = fs_q;
  assign O_underflow   = uf_q;

endmodule
